// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan controller: blanking values,
// active-low hex glyph table and counter width helper.
package seg_pkg;

  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam logic [63:0] AN_OFF    = '1;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seseg.sv
// Hex nibble to active-low 7-segment pattern decoder.
module seseg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_GLYPH[hex];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an NDIG-digit common-anode display,
// with guard blanking, leading-zero suppression and frame-aligned value load.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NDIG  = 4,
  parameter int unsigned DIV   = 50000,
  parameter int unsigned GUARD = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*NDIG-1:0] val,
  input  logic [NDIG-1:0]   dp_in,
  input  logic              lzs,
  input  logic              load,
  output logic              ack,
  output logic              frame,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        seg,
  output logic              dp
);

  localparam int unsigned CW = cnt_w(DIV);
  localparam int unsigned IW = cnt_w(NDIG);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0] shadow_q, shadow_d;
  logic [NDIG-1:0]   shdp_q, shdp_d;
  logic              ack_q, ack_d;
  logic              frame_q, frame_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic              slot_end;
  logic              boundary;
  logic [NDIG-1:0]   supp;
  logic [3:0]        cur_digit;
  logic [6:0]        dec_seg;

  assign slot_end = (cnt_q == CW'(DIV - 1));
  assign boundary = slot_end && (idx_q == IW'(NDIG - 1));

  always_comb begin
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    ack_d    = boundary & load;
    frame_d  = boundary;
    shadow_d = shadow_q;
    shdp_d   = shdp_q;
    if (boundary && load) begin
      shadow_d = val;
      shdp_d   = dp_in;
    end
  end

  // Walk from the top digit down: a digit stays blank only while everything
  // at or above it is zero with no decimal point.
  always_comb begin
    logic        live;
    int unsigned i;
    supp = '0;
    live = 1'b0;
    for (int unsigned k = 0; k < NDIG - 1; k++) begin
      i       = NDIG - 1 - k;
      live    = live | (shadow_q[4*i +: 4] != 4'h0) | shdp_q[i];
      supp[i] = lzs & ~live;
    end
  end

  assign cur_digit = shadow_q[{idx_q, 2'b00} +: 4];

  seseg u_seseg (
    .hex (cur_digit),
    .seg (dec_seg)
  );

  always_comb begin
    an_d = AN_OFF[NDIG-1:0];
    if ((cnt_q >= CW'(GUARD)) && !supp[idx_q]) begin
      an_d[idx_q] = 1'b0;
    end
    seg_d = supp[idx_q] ? SEG_BLANK : dec_seg;
    dp_d  = supp[idx_q] | ~shdp_q[idx_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      shdp_q   <= '0;
      ack_q    <= 1'b0;
      frame_q  <= 1'b0;
      an_q     <= AN_OFF[NDIG-1:0];
      seg_q    <= SEG_BLANK;
      dp_q     <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      shdp_q   <= shdp_d;
      ack_q    <= ack_d;
      frame_q  <= frame_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign ack   = ack_q;
  assign frame = frame_q;
  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;

endmodule
